mult_pipe: RTL

Pipelined, parametrised signed fixed-point multiplier with valid/ready flow control, selectable rounding and optional saturation. It is the next-generation replacement for the combinational two-input multiplier used across the neuron, weight-update and backprop datapaths. The new block registers the full-precision product and applies rounding and overflow handling in a later stage, which closes timing at WIDTH=32. It also adds downstream backpressure, so it drops into streaming layer pipelines without external skid logic.

---
 rtl/mult_pkg.sv | 16 +
 rtl/fxp_round_sat.sv | 39 +++
 rtl/mult_pipe.sv | 69 ++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared fixed-point constants and saturation-bound helpers for the
// multiplier and accumulator datapaths.
package mult_pkg;
  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_HALF_UP = 1;
  localparam int FXP_MAXW      = 64;

  // Bounds are returned in FXP_MAXW bits; callers keep the low WIDTH bits.
  function automatic logic [FXP_MAXW-1:0] fxp_max(input int width);
    fxp_max = {FXP_MAXW{1'b1}} >> (FXP_MAXW - width + 1);
  endfunction

  function automatic logic [FXP_MAXW-1:0] fxp_min(input int width);
    fxp_min = ~fxp_max(width);
  endfunction
endpackage

// File: rtl/fxp_round_sat.sv
// Combinational rescale of a 2*WIDTH signed product back to WIDTH bits,
// with optional half-up rounding and optional saturation on overflow.
module fxp_round_sat
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 24,
  parameter int ROUND = ROUND_HALF_UP,
  parameter int SAT   = 1
) (
  input  logic signed [2*WIDTH-1:0] i_p,
  output logic        [WIDTH-1:0]   o_r,
  output logic                      o_ovf
);
  localparam logic [FXP_MAXW-1:0] W_MAX = fxp_max(WIDTH);
  localparam logic [FXP_MAXW-1:0] W_MIN = fxp_min(WIDTH);

  logic signed [2*WIDTH:0]       w_ext;
  logic signed [2*WIDTH:0]       w_sh;
  logic        [2*WIDTH:0]       w_r;
  logic                          w_rbit;
  logic        [WIDTH+1:0]       w_top;

  // One extra bit so the rounding carry out of the max product cannot wrap.
  assign w_ext  = {i_p[2*WIDTH-1], i_p};
  assign w_sh   = w_ext >>> FRAC;
  assign w_rbit = (ROUND == ROUND_HALF_UP) ? i_p[FRAC-1] : 1'b0;
  assign w_r    = w_sh + {{(2*WIDTH){1'b0}}, w_rbit};

  // Fits in WIDTH bits only if everything above the result sign bit agrees.
  assign w_top  = w_r[2*WIDTH:WIDTH-1];
  assign o_ovf  = !((&w_top) || (~|w_top));

  always_comb begin
    o_r = w_r[WIDTH-1:0];
    if ((SAT != 0) && o_ovf)
      o_r = w_r[2*WIDTH] ? W_MIN[WIDTH-1:0] : W_MAX[WIDTH-1:0];
  end
endmodule

// File: rtl/mult_pipe.sv
// Pipelined signed fixed-point multiplier with valid/ready flow control;
// the whole pipe advances together whenever the output slot is free or drained.
module mult_pipe
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 24,
  parameter int LAT   = 2,
  parameter int ROUND = ROUND_HALF_UP,
  parameter int SAT   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] i_a,
  input  logic signed [WIDTH-1:0] i_b,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic        [WIDTH-1:0] o,
  output logic                    o_ovf,
  output logic                    o_valid,
  input  logic                    i_ready
);
  logic                          w_adv;
  logic        [WIDTH-1:0]       w_r;
  logic                          w_ovf;

  logic        [LAT:1]           r_vld;
  logic signed [2*WIDTH-1:0]     r_p;
  logic        [LAT:2][WIDTH-1:0] r_d;
  logic        [LAT:2]           r_ovf;

  assign w_adv   = !r_vld[LAT] || i_ready;
  assign o_ready = w_adv && !rst;

  fxp_round_sat #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .ROUND (ROUND),
    .SAT   (SAT)
  ) u_rs (
    .i_p   (r_p),
    .o_r   (w_r),
    .o_ovf (w_ovf)
  );

  // While adv=1 and rst=0, o_ready=1, so i_valid alone marks an accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      r_p   <= '0;
      r_d   <= '0;
      r_ovf <= '0;
    end else if (w_adv) begin
      r_vld[1]     <= i_valid;
      r_vld[LAT:2] <= r_vld[LAT-1:1];
      r_p          <= i_a * i_b;
      r_d[2]       <= w_r;
      r_ovf[2]     <= w_ovf;
      for (int k = 3; k <= LAT; k++) begin
        r_d[k]   <= r_d[k-1];
        r_ovf[k] <= r_ovf[k-1];
      end
    end
  end

  assign o       = r_d[LAT];
  assign o_ovf   = r_ovf[LAT];
  assign o_valid = r_vld[LAT];
endmodule
